// File: rtl/common_pkg.sv
// Scalar types shared by every pipeline stage.
package common;

    typedef logic [63:0] addr_t;
    typedef logic [31:0] u32;
    typedef logic [63:0] word_t;

endpackage

// File: rtl/pipeline_pkg.sv
// Inter-stage records and fetch-stage constants.
package pipeline;

    import common::*;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DISCARD,
        WAITOUT
    } fetch_state_t;

    localparam addr_t PCINIT_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        addr_t pc;
        u32    raw_instr;
    } fetch_instr_t;

    typedef struct packed {
        logic         valid;
        fetch_instr_t instr;
    } fetch_data_t;

endpackage

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, keeps one request on the instruction bus
// at a time and hands each returned word to decode as a registered fetch_data_t.
module fetch
    import common::*;
    import pipeline::*;
#(
    parameter addr_t PCINIT = PCINIT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output addr_t       ireq_addr,
    input  logic        iresp_data_ok,
    input  u32          iresp_data,
    output fetch_data_t dataF,
    input  logic        stall,
    input  logic        redirect_valid,
    input  addr_t       redirect_pc
);

    fetch_state_t state, state_next;
    addr_t        pc, pc_next;
    addr_t        pending_pc, pending_pc_next;
    fetch_data_t  data_next;

    // The request is held steady from the state register alone, so the bus
    // sees a constant address until its response arrives.
    assign ireq_valid = (state == FETCH) || (state == DISCARD);
    assign ireq_addr  = pc;

    always_comb begin
        // NOTE: every next value defaults to its current register, so no path leaves it unassigned (no latch).
        state_next      = state;
        pc_next         = pc;
        pending_pc_next = pending_pc;
        data_next       = dataF;
        case (state)
            IDLE: begin
                state_next = FETCH;
                if (redirect_valid) pc_next = redirect_pc;
            end
            FETCH: begin
                if (iresp_data_ok) begin
                    if (redirect_valid) begin
                        pc_next = redirect_pc;
                    end else begin
                        data_next.valid           = 1'b1;
                        data_next.instr.pc        = pc;
                        data_next.instr.raw_instr = iresp_data;
                        pc_next                   = pc + 64'd4;
                        state_next                = WAITOUT;
                    end
                end else if (redirect_valid) begin
                    pending_pc_next = redirect_pc;
                    state_next      = DISCARD;
                end
            end
            DISCARD: begin
                // The wrong-path response must still be consumed before the bus can move on.
                if (iresp_data_ok) begin
                    pc_next    = redirect_valid ? redirect_pc : pending_pc;
                    state_next = FETCH;
                end else if (redirect_valid) begin
                    pending_pc_next = redirect_pc;
                end
            end
            WAITOUT: begin
                if (redirect_valid) begin
                    data_next.valid = 1'b0;
                    pc_next         = redirect_pc;
                    state_next      = FETCH;
                end else if (!stall) begin
                    data_next.valid = 1'b0;
                    state_next      = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the blocking ones live in the comb block.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pc         <= PCINIT;
            pending_pc <= '0;
            dataF      <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pending_pc <= pending_pc_next;
            dataF      <= data_next;
        end
    end

endmodule
